issue_unit_arbiter: RTL and testbench
=====================================

Name: issue_unit_arbiter

Overview:
- Issue scheduler between the four issue queues (Int, LS, Mult, Div) and their execution units.
- Selects at most one ready instruction per cycle and drives each queue's issue strobe combinationally, in the same cycle as that queue's ready.
- Keeps a CDB reservation register so no two results reach the CDB in the same cycle, and tracks the non-pipelined divider's busy time.
- Publishes the registered CDB owner each cycle for the CDB mux.

Parameters:
- INT_LAT, 1, cycles from issue to CDB for integer ops
- LD_LAT, 2, cycles from issue to CDB for loads
- MUL_LAT, 4, cycles from issue to CDB for multiply (pipelined)
- DIV_LAT, 7, cycles from issue to CDB for divide (non-pipelined); must be the largest latency

Ports:
- Clk  in  1  clock
- Rst  in  1  asynchronous, active-high reset
- IssueQue_Ready_Int  in  1  Int queue holds an issuable entry
- IssueQue_Ready_LS  in  1  LS queue holds an issuable entry
- IssueQue_Opcode_LS  in  1  opcode of the LS head candidate: 1 = load, 0 = store
- IssueQue_Ready_Mult  in  1  Mult queue ready
- IssueQue_Ready_Div  in  1  Div queue ready
- RB_Flush_Valid  in  1  flush from retire bus
- Issue_Int  out  1  grant to Int queue (Issueblk_Issue)
- Issue_LS  out  1  grant to LS queue
- Issue_Mult  out  1  grant to Mult queue
- Issue_Div  out  1  grant to Div queue
- Cdb_Owner  out  2  unit driving the CDB this cycle: 0 Int, 1 LS, 2 Mult, 3 Div
- Cdb_Owner_Val  out  1  Cdb_Owner is valid
- Div_Busy  out  1  divider occupied

Behaviour:
- Reset (asynchronous): all reservation slots cleared, Cdb_Owner_Val=0, Cdb_Owner=0, div_cnt=0, Div_Busy=0, last_grant=3 (so Int is searched first). Grants are combinational and therefore 0 when nothing is eligible.
- Reservation register res[0..DIV_LAT]:
  - Each entry is {v, owner[1:0]}.
  - res[k] describes CDB use k cycles from now.
  - Cdb_Owner_Val = res[0].v and Cdb_Owner = res[0].owner, both straight from flops.
- Per-clock update:
  - Shift: res[k] <= res[k+1]; res[DIV_LAT] <= 0.
  - On a grant of unit u with latency L: res[L-1] <= {1, u}.
  - Net effect: a grant at cycle t yields Cdb_Owner_Val=1, Cdb_Owner=u at cycle t+L.
- Eligibility in cycle t:
  - Int: ready and !res[INT_LAT].v.
  - Mult: ready and !res[MUL_LAT].v.
  - Div: ready and !res[DIV_LAT].v and div_cnt==0.
  - LS load (Opcode_LS=1): ready and !res[LD_LAT].v.
  - LS store (Opcode_LS=0): ready only; a store reserves no slot and never produces a CDB owner.
- Arbitration:
  - Round-robin over eligible units, searching from (last_grant+1) mod 4.
  - At most one Issue_* high per cycle (one-hot or zero).
  - last_grant updates only on a grant.
- Divider counter:
  - Loaded with DIV_LAT-1 on a Div grant; decrements toward 0 every cycle.
  - Div_Busy = (div_cnt != 0), registered.
  - Back-to-back divides are therefore spaced exactly DIV_LAT cycles apart.
- Flush:
  - RB_Flush_Valid=1 forces all Issue_* to 0 in that cycle.
  - Next edge: every res entry, div_cnt and Div_Busy go to 0. last_grant is unchanged.
  - Cdb_Owner_Val=0 in the cycle after the flush.
  - A flush overrides both the shift and the insertion in that cycle.
- Simultaneous events:
  - A slot is vacated by the shift in the same edge it is filled; no conflict arises because insertion index L-1 is tested against res[L] before the shift.
  - Ready inputs that deassert mid-cycle simply make the unit ineligible; no state is held.
- Reset asserted mid-operation discards all reservations immediately; results still in flight are not tracked.

Decomposition:
- Shared package issue_pkg:
  - unit ID constants UNIT_INT=0, UNIT_LS=1, UNIT_MULT=2, UNIT_DIV=3;
  - reservation slot typedef {v, owner};
  - default latency constants.
- Natural sub-module: cdb_reservation_shifter, holding the res register, shift/insert/flush logic, and exporting per-latency busy bits plus res[0].
- The round-robin picker and div counter stay in the top module.

Test Plan:
- Reset, then Ready_Int=1 for one cycle at t0 -> Issue_Int=1 at t0; Cdb_Owner_Val=1, Cdb_Owner=0 at t1; all outputs otherwise 0.
- CDB collision:
  - Stimulus: Mult granted at t; Ready_Int=1 from t+3.
  - Issue_Int=0 at t+3 (slot t+4 taken).
  - Issue_Int=1 at t+4.
  - Cdb_Owner=2 at t+4, then 0 at t+5.
- Fairness:
  - Stimulus: all four ready continuously from reset, Opcode_LS=1.
  - Grants are Int at t0, LS at t1, Mult at t2, Div at t3.
  - Owners appear as 0 at t1, 1 at t3, 2 at t6, 3 at t10.
- Divider spacing: only Ready_Div=1 continuously -> Issue_Div at t0, t7, t14; Div_Busy=1 during t1..t6; owner 3 at t7, t14.
- Store:
  - Stimulus: Ready_LS=1, Opcode_LS=0, and a Mult granted at t-2 (slot t+2 taken).
  - Issue_LS=1 at t.
  - Cdb_Owner_Val=0 at t+2 for LS; only Mult (owner 2) appears, at t+2.
- Flush: Mult granted at t, RB_Flush_Valid=1 at t+1 with Ready_Int=1 -> Issue_Int=0 at t+1; Cdb_Owner_Val stays 0 at t+4; Int is granted at t+2.

Source files
------------

// File: rtl/issue_pkg.sv
// -----------------------------------------------------------------------------
// issue_pkg
// Shared definitions for the issue arbiter and its CDB reservation shifter:
//   - unit IDs used for both the grant index and the CDB owner code
//   - default issue-to-CDB latencies per execution unit
//   - the reservation slot record {v, owner}
// -----------------------------------------------------------------------------
package issue_pkg;

   localparam logic [1:0] UNIT_INT  = 2'd0;
   localparam logic [1:0] UNIT_LS   = 2'd1;
   localparam logic [1:0] UNIT_MULT = 2'd2;
   localparam logic [1:0] UNIT_DIV  = 2'd3;

   // Divide must remain the longest latency: it sizes the reservation window.
   localparam int DEF_INT_LAT = 1;
   localparam int DEF_LD_LAT  = 2;
   localparam int DEF_MUL_LAT = 4;
   localparam int DEF_DIV_LAT = 7;

   typedef struct packed {
      logic       v;
      logic [1:0] owner;
   } res_slot_t;

endpackage

// File: rtl/cdb_reservation_shifter.sv
// -----------------------------------------------------------------------------
// cdb_reservation_shifter
// Holds the CDB reservation window res[0..DIV_LAT]; res[k] describes CDB use
// k cycles from now. Each clock the window shifts toward slot 0 and an
// optional new reservation is written at slot (latency-1) of its owner, so a
// grant at cycle t shows up in slot 0 at cycle t+latency.
// Ports:
//   Clk, Rst       clock, asynchronous active-high reset
//   flush          clears the whole window on the next edge (wins over all)
//   ins_valid      write a reservation for ins_owner this edge
//   ins_owner      unit ID being reserved; selects the insertion slot
//   lat_busy[u]    res[latency of unit u].v, indexed by unit ID
//   head           res[0], the registered CDB owner for this cycle
// -----------------------------------------------------------------------------
module cdb_reservation_shifter
   import issue_pkg::*;
#(
   parameter int INT_LAT = DEF_INT_LAT,
   parameter int LD_LAT  = DEF_LD_LAT,
   parameter int MUL_LAT = DEF_MUL_LAT,
   parameter int DIV_LAT = DEF_DIV_LAT
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       flush,
   input  logic       ins_valid,
   input  logic [1:0] ins_owner,
   output logic [3:0] lat_busy,
   output res_slot_t  head
);

   localparam int IDX_W = $clog2(DIV_LAT + 1);

   res_slot_t        res [0:DIV_LAT];
   logic [IDX_W-1:0] ins_idx;

   // Insertion slot is one less than the unit's latency because the same edge
   // also shifts the window down by one.
   always_comb begin
      ins_idx = IDX_W'(DIV_LAT - 1);
      case (ins_owner)
         UNIT_INT:  ins_idx = IDX_W'(INT_LAT - 1);
         UNIT_LS:   ins_idx = IDX_W'(LD_LAT - 1);
         UNIT_MULT: ins_idx = IDX_W'(MUL_LAT - 1);
         default:   ins_idx = IDX_W'(DIV_LAT - 1);
      endcase
   end

   // Window register: shift, then overlay the new reservation; a flush drops
   // every pending result including the one being inserted.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         for (int k = 0; k <= DIV_LAT; k++) res[k] <= '0;
      end else if (flush) begin
         for (int k = 0; k <= DIV_LAT; k++) res[k] <= '0;
      end else begin
         for (int k = 0; k < DIV_LAT; k++) res[k] <= res[k+1];
         res[DIV_LAT] <= '0;
         if (ins_valid) res[ins_idx] <= '{v: 1'b1, owner: ins_owner};
      end
   end

   // Eligibility looks at res[L] before the shift, i.e. the slot a grant this
   // cycle would occupy once the window has moved.
   always_comb begin
      lat_busy            = '0;
      lat_busy[UNIT_INT]  = res[INT_LAT].v;
      lat_busy[UNIT_LS]   = res[LD_LAT].v;
      lat_busy[UNIT_MULT] = res[MUL_LAT].v;
      lat_busy[UNIT_DIV]  = res[DIV_LAT].v;
      head                = res[0];
   end

endmodule

// File: rtl/issue_unit_arbiter.sv
// -----------------------------------------------------------------------------
// issue_unit_arbiter
// Picks at most one ready issue queue per cycle (round-robin over Int, LS,
// Mult, Div), avoiding CDB collisions via a reservation window and keeping the
// non-pipelined divider from being re-issued while busy.
// Ports:
//   Clk, Rst                  clock, asynchronous active-high reset
//   IssueQue_Ready_*          per-queue "has an issuable entry"
//   IssueQue_Opcode_LS        1 = load (needs CDB), 0 = store (no CDB)
//   RB_Flush_Valid            kills grants now, clears all tracking next edge
//   Issue_*                   combinational one-hot (or zero) grants
//   Cdb_Owner, Cdb_Owner_Val  registered owner of the CDB this cycle
//   Div_Busy                  divider occupied (registered)
// -----------------------------------------------------------------------------
module issue_unit_arbiter
   import issue_pkg::*;
#(
   parameter int INT_LAT = DEF_INT_LAT,
   parameter int LD_LAT  = DEF_LD_LAT,
   parameter int MUL_LAT = DEF_MUL_LAT,
   parameter int DIV_LAT = DEF_DIV_LAT
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       IssueQue_Ready_Int,
   input  logic       IssueQue_Ready_LS,
   input  logic       IssueQue_Opcode_LS,
   input  logic       IssueQue_Ready_Mult,
   input  logic       IssueQue_Ready_Div,
   input  logic       RB_Flush_Valid,
   output logic       Issue_Int,
   output logic       Issue_LS,
   output logic       Issue_Mult,
   output logic       Issue_Div,
   output logic [1:0] Cdb_Owner,
   output logic       Cdb_Owner_Val,
   output logic       Div_Busy
);

   localparam int CNT_W = $clog2(DIV_LAT + 1);

   logic [3:0]       lat_busy;
   res_slot_t        head;
   logic [3:0]       eligible;
   logic [1:0]       last_grant;
   logic [1:0]       rr_cand;
   logic             grant_found;
   logic [1:0]       grant_unit;
   logic             ins_valid;
   logic [CNT_W-1:0] div_cnt;
   logic [CNT_W-1:0] div_cnt_next;

   cdb_reservation_shifter #(
      .INT_LAT (INT_LAT),
      .LD_LAT  (LD_LAT),
      .MUL_LAT (MUL_LAT),
      .DIV_LAT (DIV_LAT)
   ) u_res (
      .Clk       (Clk),
      .Rst       (Rst),
      .flush     (RB_Flush_Valid),
      .ins_valid (ins_valid),
      .ins_owner (grant_unit),
      .lat_busy  (lat_busy),
      .head      (head)
   );

   // A store never touches the CDB, so it only needs its queue to be ready.
   always_comb begin
      eligible            = '0;
      eligible[UNIT_INT]  = IssueQue_Ready_Int && !lat_busy[UNIT_INT];
      eligible[UNIT_LS]   = IssueQue_Ready_LS &&
                            (!IssueQue_Opcode_LS || !lat_busy[UNIT_LS]);
      eligible[UNIT_MULT] = IssueQue_Ready_Mult && !lat_busy[UNIT_MULT];
      eligible[UNIT_DIV]  = IssueQue_Ready_Div && !lat_busy[UNIT_DIV] &&
                            (div_cnt == '0);
   end

   // Round-robin search starting just after the previous winner; the fourth
   // candidate wraps back to the previous winner itself.
   always_comb begin
      grant_found = 1'b0;
      grant_unit  = last_grant;
      rr_cand     = last_grant;
      for (int i = 1; i <= 4; i++) begin
         rr_cand = last_grant + 2'(i);
         if (!grant_found && eligible[rr_cand]) begin
            grant_found = 1'b1;
            grant_unit  = rr_cand;
         end
      end
      if (RB_Flush_Valid) grant_found = 1'b0;
   end

   // Grant strobes and reservation request; stores issue without a slot.
   always_comb begin
      Issue_Int  = grant_found && (grant_unit == UNIT_INT);
      Issue_LS   = grant_found && (grant_unit == UNIT_LS);
      Issue_Mult = grant_found && (grant_unit == UNIT_MULT);
      Issue_Div  = grant_found && (grant_unit == UNIT_DIV);
      ins_valid  = grant_found && !((grant_unit == UNIT_LS) && !IssueQue_Opcode_LS);
   end

   // Round-robin pointer; reset value makes Int the first unit searched.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)              last_grant <= UNIT_DIV;
      else if (grant_found) last_grant <= grant_unit;
   end

   // Divider occupancy: loaded with DIV_LAT-1 so the next divide can issue
   // exactly DIV_LAT cycles after the previous one.
   always_comb begin
      div_cnt_next = div_cnt;
      if (Issue_Div)           div_cnt_next = CNT_W'(DIV_LAT - 1);
      else if (div_cnt != '0)  div_cnt_next = div_cnt - 1'b1;
   end

   // Div_Busy is registered alongside the counter so it is glitch-free.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         div_cnt  <= '0;
         Div_Busy <= 1'b0;
      end else if (RB_Flush_Valid) begin
         div_cnt  <= '0;
         Div_Busy <= 1'b0;
      end else begin
         div_cnt  <= div_cnt_next;
         Div_Busy <= (div_cnt_next != '0);
      end
   end

   assign Cdb_Owner_Val = head.v;
   assign Cdb_Owner     = head.owner;

endmodule

// File: tb/tb_issue_unit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_issue_unit_arbiter
// Directed vector table for the documented scenarios, a hand-written
// mid-operation reset sequence, then random stimulus checked against a
// cycle-booking reference model (absolute-time CDB calendar).
// -----------------------------------------------------------------------------
module tb_issue_unit_arbiter;

   logic       Clk = 1'b0;
   logic       Rst;
   logic       IssueQue_Ready_Int, IssueQue_Ready_LS, IssueQue_Opcode_LS;
   logic       IssueQue_Ready_Mult, IssueQue_Ready_Div, RB_Flush_Valid;
   logic       Issue_Int, Issue_LS, Issue_Mult, Issue_Div;
   logic [1:0] Cdb_Owner;
   logic       Cdb_Owner_Val, Div_Busy;

   typedef struct {
      bit ri, rls, op, rm, rd, fl;
   } stim_t;

   typedef struct {
      logic [3:0] issue;   // {Div, Mult, LS, Int}
      bit         val;
      logic [1:0] owner;
      bit         busy;
   } exp_t;

   typedef struct {
      bit    do_reset;
      stim_t s;
      exp_t  e;
      string name;
   } vec_t;

   int passCount  = 0;
   int checkCount = 0;

   // Reference model: CDB calendar indexed by absolute cycle (mod 16),
   // -1 means free.
   int mdlBook [16];
   int mdlNow, mdlLast, mdlDivReady, mdlGrant;
   int unitLat [4] = '{1, 2, 4, 7};

   vec_t vecs [$];

   always #5 Clk = ~Clk;

   issue_unit_arbiter dut (
      .Clk                 (Clk),
      .Rst                 (Rst),
      .IssueQue_Ready_Int  (IssueQue_Ready_Int),
      .IssueQue_Ready_LS   (IssueQue_Ready_LS),
      .IssueQue_Opcode_LS  (IssueQue_Opcode_LS),
      .IssueQue_Ready_Mult (IssueQue_Ready_Mult),
      .IssueQue_Ready_Div  (IssueQue_Ready_Div),
      .RB_Flush_Valid      (RB_Flush_Valid),
      .Issue_Int           (Issue_Int),
      .Issue_LS            (Issue_LS),
      .Issue_Mult          (Issue_Mult),
      .Issue_Div           (Issue_Div),
      .Cdb_Owner           (Cdb_Owner),
      .Cdb_Owner_Val       (Cdb_Owner_Val),
      .Div_Busy            (Div_Busy)
   );

   // Single comparison with failure reporting.
   task automatic check1(input string tag, input int actual, input int required);
      checkCount++;
      if (actual == required) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, required);
   endtask

   task automatic modelReset();
      for (int i = 0; i < 16; i++) mdlBook[i] = -1;
      mdlNow      = 0;
      mdlLast     = 3;
      mdlDivReady = 0;
      mdlGrant    = -1;
   endtask

   // Expected outputs for the current cycle from the calendar and RR rules.
   task automatic modelExpect(input stim_t s, output exp_t e);
      bit el [4];
      int u;
      el[0] = s.ri && (mdlBook[(mdlNow + 1) % 16] < 0);
      el[1] = s.rls && (!s.op || (mdlBook[(mdlNow + 2) % 16] < 0));
      el[2] = s.rm && (mdlBook[(mdlNow + 4) % 16] < 0);
      el[3] = s.rd && (mdlBook[(mdlNow + 7) % 16] < 0) && (mdlNow >= mdlDivReady);
      mdlGrant = -1;
      if (!s.fl) begin
         for (int i = 1; i <= 4; i++) begin
            u = (mdlLast + i) % 4;
            if (mdlGrant < 0 && el[u]) mdlGrant = u;
         end
      end
      e.issue = 4'b0000;
      if (mdlGrant >= 0) e.issue[mdlGrant] = 1'b1;
      e.val   = (mdlBook[mdlNow % 16] >= 0);
      e.owner = e.val ? 2'(mdlBook[mdlNow % 16]) : 2'd0;
      e.busy  = (mdlNow < mdlDivReady);
   endtask

   task automatic modelUpdate(input stim_t s);
      if (s.fl) begin
         for (int i = 0; i < 16; i++) mdlBook[i] = -1;
         mdlDivReady = 0;
      end else begin
         if (mdlGrant >= 0) begin
            if (!(mdlGrant == 1 && !s.op))
               mdlBook[(mdlNow + unitLat[mdlGrant]) % 16] = mdlGrant;
            mdlLast = mdlGrant;
            if (mdlGrant == 3) mdlDivReady = mdlNow + 7;
         end
         mdlBook[mdlNow % 16] = -1;
      end
      mdlNow++;
   endtask

   task automatic applyStimulus(input stim_t s);
      IssueQue_Ready_Int  = s.ri;
      IssueQue_Ready_LS   = s.rls;
      IssueQue_Opcode_LS  = s.op;
      IssueQue_Ready_Mult = s.rm;
      IssueQue_Ready_Div  = s.rd;
      RB_Flush_Valid      = s.fl;
   endtask

   task automatic checkOutput(input exp_t e, input string tag);
      check1({tag, ".issue"}, int'({Issue_Div, Issue_Mult, Issue_LS, Issue_Int}), int'(e.issue));
      check1({tag, ".val"}, int'(Cdb_Owner_Val), int'(e.val));
      if (e.val) check1({tag, ".owner"}, int'(Cdb_Owner), int'(e.owner));
      check1({tag, ".busy"}, int'(Div_Busy), int'(e.busy));
   endtask

   // One cycle: drive after the edge, compare on the falling edge.
   task automatic runStep(input stim_t s, input bit useTable, input exp_t te, input string tag);
      exp_t me;
      applyStimulus(s);
      @(negedge Clk);
      modelExpect(s, me);
      checkOutput(useTable ? te : me, tag);
      modelUpdate(s);
      @(posedge Clk);
      #1;
   endtask

   task automatic doReset();
      stim_t z;
      z = '{default: 1'b0};
      applyStimulus(z);
      Rst = 1'b1;
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      modelReset();
   endtask

   // Inputs packed as {ri, rls, op, rm, rd, fl}.
   function automatic vec_t mk(bit rst, bit [5:0] in, logic [3:0] iss, bit val,
                               logic [1:0] own, bit busy, string name);
      vec_t v;
      v.do_reset = rst;
      v.s.ri  = in[5]; v.s.rls = in[4]; v.s.op = in[3];
      v.s.rm  = in[2]; v.s.rd  = in[1]; v.s.fl = in[0];
      v.e.issue = iss; v.e.val = val; v.e.owner = own; v.e.busy = busy;
      v.name = name;
      return v;
   endfunction

   initial begin
      stim_t s;
      exp_t  dummy;
      dummy = '{issue: 4'b0, val: 1'b0, owner: 2'd0, busy: 1'b0};
      Rst = 1'b1;
      s = '{default: 1'b0};
      applyStimulus(s);
      modelReset();

      // Single Int issue
      vecs.push_back(mk(1, 6'b000000, 4'b0000, 0, 0, 0, "rst_idle"));
      vecs.push_back(mk(0, 6'b100000, 4'b0001, 0, 0, 0, "int_t0"));
      vecs.push_back(mk(0, 6'b000000, 4'b0000, 1, 0, 0, "int_t1"));
      vecs.push_back(mk(0, 6'b000000, 4'b0000, 0, 0, 0, "int_t2"));
      // CDB collision with an in-flight multiply
      vecs.push_back(mk(1, 6'b000100, 4'b0100, 0, 0, 0, "col_t0"));
      vecs.push_back(mk(0, 6'b000000, 4'b0000, 0, 0, 0, "col_t1"));
      vecs.push_back(mk(0, 6'b000000, 4'b0000, 0, 0, 0, "col_t2"));
      vecs.push_back(mk(0, 6'b100000, 4'b0000, 0, 0, 0, "col_t3"));
      vecs.push_back(mk(0, 6'b100000, 4'b0001, 1, 2, 0, "col_t4"));
      vecs.push_back(mk(0, 6'b000000, 4'b0000, 1, 0, 0, "col_t5"));
      vecs.push_back(mk(0, 6'b000000, 4'b0000, 0, 0, 0, "col_t6"));
      // Fairness, all ready with a load at the LS head
      vecs.push_back(mk(1, 6'b111110, 4'b0001, 0, 0, 0, "fair_t0"));
      vecs.push_back(mk(0, 6'b111110, 4'b0010, 1, 0, 0, "fair_t1"));
      vecs.push_back(mk(0, 6'b111110, 4'b0100, 0, 0, 0, "fair_t2"));
      vecs.push_back(mk(0, 6'b111110, 4'b1000, 1, 1, 0, "fair_t3"));
      vecs.push_back(mk(0, 6'b111110, 4'b0001, 0, 0, 1, "fair_t4"));
      vecs.push_back(mk(0, 6'b111110, 4'b0010, 1, 0, 1, "fair_t5"));
      // Divider spacing
      vecs.push_back(mk(1, 6'b000010, 4'b1000, 0, 0, 0, "div_t0"));
      for (int i = 1; i <= 6; i++)
         vecs.push_back(mk(0, 6'b000010, 4'b0000, 0, 0, 1, $sformatf("div_t%0d", i)));
      vecs.push_back(mk(0, 6'b000010, 4'b1000, 1, 3, 0, "div_t7"));
      vecs.push_back(mk(0, 6'b000010, 4'b0000, 0, 0, 1, "div_t8"));
      // Store issues into a taken slot and never owns the CDB
      vecs.push_back(mk(1, 6'b000100, 4'b0100, 0, 0, 0, "st_tm2"));
      vecs.push_back(mk(0, 6'b000000, 4'b0000, 0, 0, 0, "st_tm1"));
      vecs.push_back(mk(0, 6'b010000, 4'b0010, 0, 0, 0, "st_t0"));
      vecs.push_back(mk(0, 6'b000000, 4'b0000, 0, 0, 0, "st_t1"));
      vecs.push_back(mk(0, 6'b000000, 4'b0000, 1, 2, 0, "st_t2"));
      vecs.push_back(mk(0, 6'b000000, 4'b0000, 0, 0, 0, "st_t3"));
      // Flush kills the grant and the in-flight multiply
      vecs.push_back(mk(1, 6'b000100, 4'b0100, 0, 0, 0, "fl_t0"));
      vecs.push_back(mk(0, 6'b100001, 4'b0000, 0, 0, 0, "fl_t1"));
      vecs.push_back(mk(0, 6'b100000, 4'b0001, 0, 0, 0, "fl_t2"));
      vecs.push_back(mk(0, 6'b000000, 4'b0000, 1, 0, 0, "fl_t3"));
      vecs.push_back(mk(0, 6'b000000, 4'b0000, 0, 0, 0, "fl_t4"));

      foreach (vecs[i]) begin
         if (vecs[i].do_reset) doReset();
         runStep(vecs[i].s, 1'b1, vecs[i].e, vecs[i].name);
      end

      // Asynchronous reset in the cycle a multiply result is due
      doReset();
      s = '{default: 1'b0};
      s.rm = 1'b1;
      runStep(s, 1'b0, dummy, "mr_t0");
      s.rm = 1'b0;
      for (int i = 1; i <= 3; i++) runStep(s, 1'b0, dummy, $sformatf("mr_t%0d", i));
      check1("mr_pre_val", int'(Cdb_Owner_Val), 1);
      check1("mr_pre_owner", int'(Cdb_Owner), 2);
      Rst = 1'b1;
      #1;
      check1("mr_async_val", int'(Cdb_Owner_Val), 0);
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      modelReset();
      runStep(s, 1'b0, dummy, "mr_after");

      // Random traffic against the calendar model
      doReset();
      for (int n = 0; n < 500; n++) begin
         s.ri  = 1'($urandom % 2);
         s.rls = 1'($urandom % 2);
         s.op  = 1'($urandom % 2);
         s.rm  = 1'($urandom % 2);
         s.rd  = 1'($urandom % 2);
         s.fl  = ($urandom_range(0, 19) == 0);
         runStep(s, 1'b0, dummy, $sformatf("rnd%0d", n));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
